pc_fetch_unit: RTL

- Program-counter and fetch-sequencing stage, directly upstream of the instruction memory.
- Drives IAddress and InsMemRW into instruction memory each cycle.
- Takes redirect, stall and halt requests from control/ALU; outputs PC+1 for link and branch use.
- Flags out-of-range targets for a 64-word instruction store.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/pc_fetch_unit_if.sv | 31 +++
 rtl/pc_next_calc.sv | 47 ++++
 rtl/pc_fetch_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, instruction-store geometry and
// opcode nibble positions used by the fetch, memory and decode blocks.
package cpu_pkg;

    localparam int ADDR_W     = 16;
    localparam int IMEM_DEPTH = 64;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Opcode nibble fields, least significant first.
    localparam int OP_NIB0_LSB = 0;
    localparam int OP_NIB1_LSB = 4;
    localparam int OP_NIB2_LSB = 8;
    localparam int OP_NIB3_LSB = 12;
    localparam int OP_NIB_W    = 4;

    typedef struct packed {
        logic [3:0] nib3;  // [15:12]
        logic [3:0] nib2;  // [11:8]
        logic [3:0] nib1;  // [7:4]
        logic [3:0] nib0;  // [3:0]
    } op_fields_t;

    function automatic logic [3:0] op_nibble(input logic [15:0] ins, input int unsigned idx);
        return ins[(idx % 4) * OP_NIB_W +: OP_NIB_W];
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control-side request bundle and instruction-memory-side fetch outputs of the PC stage.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int OFF_W  = 8
);

    logic              stall;
    logic              branch_taken;
    logic [OFF_W-1:0]  branch_off;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              halt_req;

    logic [ADDR_W-1:0] IAddress;
    logic              InsMemRW;
    logic [ADDR_W-1:0] pc_plus1;
    logic              fetch_valid;
    logic              halted;
    logic              addr_fault;

    modport master (
        output stall, branch_taken, branch_off, jump, jump_addr, halt_req,
        input  IAddress, InsMemRW, pc_plus1, fetch_valid, halted, addr_fault
    );

    modport slave (
        input  stall, branch_taken, branch_off, jump, jump_addr, halt_req,
        output IAddress, InsMemRW, pc_plus1, fetch_valid, halted, addr_fault
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC arithmetic: wrapped sequential successor, redirect
// target selection (jump over branch) and the instruction-store range check.
module pc_next_calc #(
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int IMEM_DEPTH = cpu_pkg::IMEM_DEPTH,
    parameter int OFF_W      = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [OFF_W-1:0]  branch_off,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect,
    output logic              fault
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH     = ADDR_W'(IMEM_DEPTH);

    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] target;

    // Branch offsets are relative to the raw PC+1; only sequential flow wraps at the store end.
    assign off_ext       = {{(ADDR_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
    assign branch_target = pc + ADDR_W'(1) + off_ext;
    assign pc_plus1      = (pc == LAST_ADDR) ? '0 : pc + ADDR_W'(1);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        redirect = jump | branch_taken;
        target   = jump ? jump_addr : branch_target;
        fault    = 1'b0;
        next_pc  = pc_plus1;
        if (redirect) begin
            if (target >= DEPTH) begin
                fault   = 1'b1;
                next_pc = pc;
            end else begin
                next_pc = target;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: BOOT/RUN/HALT control, PC register and
// sticky out-of-range fault, feeding the instruction memory address port.
module pc_fetch_unit #(
    parameter int ADDR_W       = cpu_pkg::ADDR_W,
    parameter int IMEM_DEPTH   = cpu_pkg::IMEM_DEPTH,
    parameter int RESET_VECTOR = 0,
    parameter int OFF_W        = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_fetch_unit_if.slave bus
);

    import cpu_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic              target_fault;
    logic              fetch_valid;

    pc_next_calc #(
        .ADDR_W     (ADDR_W),
        .IMEM_DEPTH (IMEM_DEPTH),
        .OFF_W      (OFF_W)
    ) u_next (
        .pc           (pc_q),
        .branch_taken (bus.branch_taken),
        .branch_off   (bus.branch_off),
        .jump         (bus.jump),
        .jump_addr    (bus.jump_addr),
        .pc_plus1     (pc_plus1),
        .next_pc      (next_pc),
        .redirect     (redirect),
        .fault        (target_fault)
    );

    // NOTE: only the control registers are reset; there is no storage array here to clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= ADDR_W'(RESET_VECTOR);
            fault_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fault_d     = fault_q;
        fetch_valid = 1'b0;

        unique case (state_q)
            BOOT: state_d = RUN;

            RUN: begin
                fetch_valid = ~bus.stall;
                if (bus.halt_req) begin
                    state_d = HALT;
                end else if (redirect) begin
                    // A redirect squashes the stalled fetch, so stall is not consulted here.
                    if (target_fault) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d = next_pc;
                    end
                end else if (!bus.stall) begin
                    pc_d = next_pc;
                end
            end

            HALT: ;

            default: state_d = BOOT;
        endcase
    end

    assign bus.IAddress    = pc_q;
    assign bus.InsMemRW    = 1'b0;
    assign bus.pc_plus1    = pc_plus1;
    assign bus.fetch_valid = fetch_valid;
    assign bus.halted      = (state_q == HALT);
    assign bus.addr_fault  = fault_q;

endmodule
